// File: rtl/gray_code_counter.sv
// Parametrised up/down counter with registered binary and Gray outputs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable, up          step request and direction (load wins over enable)
//   load, load_gray     parallel load, load_data taken as Gray when load_gray=1
//   load_data [W]       value to load
//   select              0 = out is binary, 1 = out is Gray
//   out [W]             registered count in the selected encoding
//   count_bin [W]       registered count, always binary
//   wrap                one-cycle pulse when a count step crosses max<->0
module gray_code_counter #(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_data,
   input  logic             select,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] count_bin,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic             wrap_q;
   logic             wrap_d;

   // Gray to binary: prefix XOR from the MSB down.
   function automatic logic [WIDTH-1:0] g2b(
      input logic [WIDTH-1:0] g
   );
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      unique casez ({load, enable})
         2'b1?: begin
            cnt_d = load_gray ? g2b(load_data) : load_data;
         end
         2'b01: begin
            if (up) begin
               cnt_d  = cnt_q + WIDTH'(1);
               wrap_d = (cnt_q == '1);
            end else begin
               cnt_d  = cnt_q - WIDTH'(1);
               wrap_d = (cnt_q == '0);
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
      // Encoding follows the next count so out and count_bin stay aligned.
      out_d = select ? (cnt_d ^ (cnt_d >> 1)) : cnt_d;
   end

   // Reset leaves out in binary form; select takes effect on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= RESET_VALUE;
         out_q  <= RESET_VALUE;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end

   assign out       = out_q;
   assign count_bin = cnt_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed and model-checked bench for gray_code_counter (WIDTH=4).
// Also builds a RESET_VALUE=5 copy to check the reset load value.
module tb_gray_code_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       up;
   logic       load;
   logic       load_gray;
   logic [3:0] load_data;
   logic       select;
   logic [3:0] out;
   logic [3:0] count_bin;
   logic       wrap;
   logic [3:0] out5;
   logic [3:0] count_bin5;
   logic       wrap5;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gray_code_counter #(.WIDTH(4), .RESET_VALUE(4'd0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .up        (up),
      .load      (load),
      .load_gray (load_gray),
      .load_data (load_data),
      .select    (select),
      .out       (out),
      .count_bin (count_bin),
      .wrap      (wrap)
   );

   gray_code_counter #(.WIDTH(4), .RESET_VALUE(4'd5)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .up        (up),
      .load      (load),
      .load_gray (load_gray),
      .load_data (load_data),
      .select    (select),
      .out       (out5),
      .count_bin (count_bin5),
      .wrap      (wrap5)
   );

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: got %b want %b", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Gray sequence for counts 1..15 then 0, worked out by hand.
   logic [3:0] gseq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0111, 4'b0101, 4'b0100, 4'b1100,
                             4'b1101, 4'b1111, 4'b1110, 4'b1010,
                             4'b1011, 4'b1001, 4'b1000, 4'b0000};

   int         m_cnt;
   int         m_nxt;
   logic       m_wrap;
   logic [3:0] m_out;
   logic [3:0] prev;
   logic [3:0] g;

   initial begin
      rst_n     = 1'b1;
      enable    = 1'b0;
      up        = 1'b1;
      load      = 1'b0;
      load_gray = 1'b0;
      load_data = 4'd0;
      select    = 1'b0;
      #2 rst_n  = 1'b0;
      #1;
      chk("rst_out", out, 4'd0);
      chk("rst_cnt", count_bin, 4'd0);
      chk("rst_wrap", {3'b0, wrap}, 4'd0);
      chk("rst5_cnt", count_bin5, 4'd5);
      chk("rst5_out", out5, 4'b0101);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Up count in Gray over a full turn.
      select = 1'b1;
      enable = 1'b1;
      up     = 1'b1;
      prev   = out;
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("up_out%0d", i), out, gseq[i]);
         chk($sformatf("up_cnt%0d", i), count_bin, 4'((i + 1) % 16));
         chk($sformatf("up_wrap%0d", i), {3'b0, wrap},
             (i == 15) ? 4'd1 : 4'd0);
         chk($sformatf("up_flip%0d", i), 4'($countones(out ^ prev)), 4'd1);
         prev = out;
      end

      // Down count from 0 in binary.
      select = 1'b0;
      up     = 1'b0;
      step();
      chk("dn_cnt0", count_bin, 4'd15);
      chk("dn_out0", out, 4'd15);
      chk("dn_wrap0", {3'b0, wrap}, 4'd1);
      step();
      chk("dn_cnt1", count_bin, 4'd14);
      chk("dn_wrap1", {3'b0, wrap}, 4'd0);
      step();
      chk("dn_cnt2", count_bin, 4'd13);

      // Load beats enable; Gray load decoded.
      select    = 1'b1;
      up        = 1'b1;
      load      = 1'b1;
      load_gray = 1'b1;
      load_data = 4'b1101;
      step();
      chk("ld_cnt", count_bin, 4'b1001);
      chk("ld_out", out, 4'b1101);
      chk("ld_wrap", {3'b0, wrap}, 4'd0);
      load_gray = 1'b0;
      load_data = 4'd15;
      step();
      chk("ld15_cnt", count_bin, 4'd15);
      load_data = 4'd0;
      step();
      chk("ld0_cnt", count_bin, 4'd0);
      chk("ld0_wrap", {3'b0, wrap}, 4'd0);

      // Hold at 6 and re-encode.
      select    = 1'b0;
      load_data = 4'd6;
      step();
      chk("hold_out_b", out, 4'b0110);
      load   = 1'b0;
      enable = 1'b0;
      select = 1'b1;
      step();
      chk("hold_out_g", out, 4'b0101);
      chk("hold_cnt", count_bin, 4'd6);
      chk("hold_wrap", {3'b0, wrap}, 4'd0);

      // Async reset mid-cycle with a load pending.
      enable    = 1'b1;
      load      = 1'b1;
      load_data = 4'd9;
      #2 rst_n  = 1'b0;
      #1;
      chk("mrst_out", out, 4'd0);
      chk("mrst_cnt", count_bin, 4'd0);
      chk("mrst_wrap", {3'b0, wrap}, 4'd0);
      chk("mrst5_out", out5, 4'd5);
      step();
      chk("mrst_hold", count_bin, 4'd0);
      rst_n  = 1'b1;
      load   = 1'b0;
      enable = 1'b0;
      select = 1'b1;
      step();
      chk("rel5_out", out5, 4'b0111);
      chk("rel5_cnt", count_bin5, 4'd5);

      // Random stimulus against an arithmetic model.
      m_cnt = 0;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         enable    = 1'($urandom_range(0, 1));
         up        = 1'($urandom_range(0, 1));
         load      = ($urandom_range(0, 7) == 0);
         load_gray = 1'($urandom_range(0, 1));
         load_data = 4'($urandom_range(0, 15));
         select    = 1'($urandom_range(0, 1));
         if (c == 700 || c == 1400) begin
            rst_n = 1'b0;
            #1;
            m_cnt = 0;
            chk("rnd_rst", count_bin, 4'd0);
            rst_n = 1'b1;
            continue;
         end
         g      = load_data;
         m_wrap = 1'b0;
         if (load) begin
            m_nxt = load_gray ? int'(g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3))
                              : int'(load_data);
         end else if (enable) begin
            m_nxt  = up ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
            m_wrap = up ? (m_cnt == 15) : (m_cnt == 0);
         end else begin
            m_nxt = m_cnt;
         end
         m_out = select ? 4'(m_nxt ^ (m_nxt / 2)) : 4'(m_nxt);
         step();
         m_cnt = m_nxt;
         chk("rnd_cnt", count_bin, 4'(m_cnt));
         chk("rnd_out", out, m_out);
         chk("rnd_wrap", {3'b0, wrap}, {3'b0, m_wrap});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
